// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the calculator operation blocks.
//   state_t       - control state of a multi-cycle operation (IDLE, CALC, DONE)
//   DEFAULT_WIDTH - default operand width in bits
package calc_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  [WIDTH:0]   - partial remainder before this step
//   bit_in              - next dividend bit, MSB first
//   divisor [WIDTH-1:0] - unsigned divisor
//   rem_out [WIDTH:0]   - partial remainder after this step
//   q_bit               - quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_in[WIDTH-1:0], bit_in};
        diff    = shifted - {1'b0, divisor};
        // The bit shifted out of the top means the true value exceeds any
        // divisor; the modular subtraction still yields the right remainder.
        q_bit   = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n    - clock and asynchronous active-low reset
//   start         - request a division (accepted in IDLE or DONE)
//   a, b          - dividend and divisor, captured on an accepted start
//   busy          - high while in CALC
//   done          - one-cycle pulse while in DONE, results valid
//   out           - {quotient, remainder}, held until the next DONE entry
//   err           - divide-by-zero flag of the last completed operation
module seq_div
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic               err
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;   // dividend, shifted left as quotient bits enter
    logic [WIDTH-1:0] dsr;   // captured divisor
    logic [WIDTH:0]   rem;   // partial remainder
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic             accept;
    logic             last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (dvd[WIDTH-1]),
        .divisor (dsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (b == '0) ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode the registered state only, so no input reaches them
    // combinationally.
    assign busy = (state == CALC);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            // NOTE: the operand registers are plain flops, not a memory
            // array, so they are reset along with the control state.
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            out   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dvd <= a;
                dsr <= b;
                rem <= '0;
                cnt <= '0;
                if (b == '0) begin
                    out <= {{WIDTH{1'b1}}, a};
                    err <= 1'b1;
                end
            end else if (state == CALC) begin
                dvd <= {dvd[WIDTH-2:0], step_q};
                rem <= step_rem;
                cnt <= cnt + 1'b1;
                if (last) begin
                    out <= {dvd[WIDTH-2:0], step_q, step_rem[WIDTH-1:0]};
                    err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: self-checking bench for seq_div with WIDTH=6.
module tb_seq_div;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] out;
    logic           err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .err   (err)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called just after a falling edge. Drives one start, then watches each
    // following falling edge until done (at most 20 cycles). Optionally
    // pulses start with other operands at CALC cycle inj_cycle.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input int inj_cycle, input logic [W-1:0] inj_a,
                          input logic [W-1:0] inj_b,
                          output logic [2*W-1:0] got_out, output logic got_err,
                          output int lat, output int busy_cnt);
        logic d_s, b_s;
        start    = 1'b1;
        a        = op_a;
        b        = op_b;
        lat      = 0;
        busy_cnt = 0;
        got_out  = '0;
        got_err  = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            d_s   = done;
            b_s   = busy;
            start = (cyc == inj_cycle);
            a     = (cyc == inj_cycle) ? inj_a : '0;
            b     = (cyc == inj_cycle) ? inj_b : '0;
            if (d_s) begin
                lat     = cyc;
                got_out = out;
                got_err = err;
                break;
            end
            if (b_s) busy_cnt++;
        end
    endtask

    logic [2*W-1:0] o;
    logic           e;
    int             lat;
    int             bc;
    int             done_seen;
    logic [W-1:0]   pa, pb;
    int             gap;

    initial begin
        vecs[0] = '{6'd45, 6'd6,  6'd7,  6'd3, 1'b0, 7};
        vecs[1] = '{6'd63, 6'd1,  6'd63, 6'd0, 1'b0, 7};
        vecs[2] = '{6'd3,  6'd10, 6'd0,  6'd3, 1'b0, 7};
        vecs[3] = '{6'd5,  6'd0,  6'd63, 6'd5, 1'b1, 1};
        vecs[4] = '{6'd8,  6'd2,  6'd4,  6'd0, 1'b0, 7};
        vecs[5] = '{6'd0,  6'd5,  6'd0,  6'd0, 1'b0, 7};
        vecs[6] = '{6'd63, 6'd63, 6'd1,  6'd0, 1'b0, 7};
        vecs[7] = '{6'd1,  6'd63, 6'd0,  6'd1, 1'b0, 7};
        vecs[8] = '{6'd62, 6'd7,  6'd8,  6'd6, 1'b0, 7};
        vecs[9] = '{6'd0,  6'd0,  6'd63, 6'd0, 1'b1, 1};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err",  32'(err),  32'd0);
        check("reset_out",  32'(out),  32'd0);

        // Release reset and start on the very next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, '0, '0, o, e, lat, bc);
            check($sformatf("vec%0d_out", i), 32'(o), 32'({vecs[i].q, vecs[i].r}));
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].e));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].lat - 1));
            @(negedge clk);
            check($sformatf("vec%0d_done_width", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_busy_idle", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d_out_hold", i), 32'(out), 32'({vecs[i].q, vecs[i].r}));
        end

        // A start pulsed mid-CALC must be ignored.
        run_op(6'd20, 6'd3, 3, 6'd9, 6'd9, o, e, lat, bc);
        check("ignore_out", 32'(o), 32'({6'd6, 6'd2}));
        check("ignore_err", 32'(e), 32'd0);
        check("ignore_lat", 32'(lat), 32'd7);
        check("ignore_busy_cycles", 32'(bc), 32'd6);
        @(negedge clk);

        // Reset asserted at CALC cycle 4 abandons the division.
        start = 1'b1;
        a     = 6'd45;
        b     = 6'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("midcalc_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out",  32'(out),  32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err",  32'(err),  32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        check("midrst_out_idle", 32'(out), 32'd0);
        run_op(6'd12, 6'd4, 0, '0, '0, o, e, lat, bc);
        check("after_rst_out", 32'(o), 32'({6'd3, 6'd0}));
        check("after_rst_err", 32'(e), 32'd0);
        check("after_rst_lat", 32'(lat), 32'd7);
        @(negedge clk);

        // Start held high: back-to-back operations against a reference model.
        start = 1'b1;
        pa    = W'($urandom_range(0, 63));
        pb    = W'($urandom_range(1, 63));
        a     = pa;
        b     = pb;
        for (int n = 0; n < 1000; n++) begin
            gap = 0;
            for (int cyc = 1; cyc <= 20; cyc++) begin
                @(negedge clk);
                if (done) begin
                    gap = cyc;
                    break;
                end
                // Operand changes during CALC must not disturb the result.
                a = W'($urandom_range(0, 63));
                b = W'($urandom_range(0, 63));
            end
            check($sformatf("b2b%0d_gap", n), 32'(gap), 32'(W + 1));
            check($sformatf("b2b%0d_out a=%0d b=%0d", n, pa, pb), 32'(out),
                  32'({W'(pa / pb), W'(pa % pb)}));
            check($sformatf("b2b%0d_err", n), 32'(err), 32'd0);
            if (gap == 0) break;
            pa = W'($urandom_range(0, 63));
            pb = W'($urandom_range(1, 63));
            a  = pa;
            b  = pb;
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b_end_done", 32'(done), 32'd0);
        check("b2b_end_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
